pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised inter-stage pipeline register for the processor datapath, used between fetch/decode/execute/memory stages in place of the hard-wired per-stage registers. It carries a PC field and a generic payload under a valid/ready handshake. It supports freeze (stall) and flush with NOP bubble injection. An optional two-entry skid buffer decouples `in_ready` from `out_ready` timing.

## Interface
- `PC_W`, 32, width of PC field
- `DATA_W`, 32, width of payload (instruction or stage control/data bundle)
- `NOP_VALUE`, 32'hF000_0000 (zero-extended/truncated to `DATA_W`), payload written on flush
- `NOP_ON_FLUSH`, 1, 1: flush loads a valid NOP bubble; 0: flush empties the stage

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `freeze`  in  1  stall: hold all state, block both handshakes
- `flush`  in  1  discard contents, optionally inject bubble; priority over `freeze`
- `in_valid`  in  1  upstream entry valid
- `in_ready`  out  1  stage can accept
- `in_pc`  in  `PC_W`  upstream PC
- `in_data`  in  `DATA_W`  upstream payload
- `out_valid`  out  1  output entry valid
- `out_ready`  in  1  downstream accepts
- `out_pc`  out  `PC_W`  registered PC
- `out_data`  out  `DATA_W`  registered payload
- `count`  out  2  entries held, 0..2 (0..1 without skid)

## Operation
- Accept = `in_valid & in_ready`; drain = `out_valid & out_ready`.
- Storage: main register (drives `out_*`) plus skid register (with `PIPE_STAGE_SKID_EN`).
- Event priority per cycle: `rst` > `flush` > `freeze` > normal.
- `rst`: `out_valid`=0, `out_pc`=0, `out_data`=0, skid empty, `count`=0. `in_ready`=0 while `rst`=1.
- `flush`: skid cleared. Main loaded with `out_pc`=0 and `out_data`=`NOP_VALUE`. `out_valid`=`NOP_ON_FLUSH`, `count`=`NOP_ON_FLUSH`. `in_ready`=0 this cycle, so the input is dropped. A drain presented in the flush cycle is not counted, because `out_valid` is forced 0 as under freeze.
- `freeze` (no flush): all registers hold. `in_ready`=0 and `out_valid` is forced to 0 combinationally, so no transfer occurs on either side.
- Normal, with skid, states EMPTY(0), ONE(1), FULL(2):
  - EMPTY + accept → ONE, main ← input.
  - ONE + accept + drain → ONE, main ← input.
  - ONE + accept, no drain → FULL, skid ← input.
  - ONE + drain, no accept → EMPTY.
  - FULL + drain → ONE, main ← skid. No accept is possible because `in_ready`=0.
  - `in_ready` = `!skid_valid & !freeze & !flush & !rst`. The skid-valid term is registered, with no combinational path from `out_ready`.
- Ordering is strictly FIFO; no entry is duplicated or lost except by flush/reset.

## Timing
- Latency: input accepted at edge N appears on `out_*` after edge N (visible in cycle N+1).
- Throughput: 1 entry/cycle sustained when `out_ready`=1.
- After one cycle of `out_ready`=0 with input streaming, FULL is reached; `in_ready` drops the following cycle.
- Flush bubble visible the cycle after the flush edge. Normal accepts resume the cycle after that.
- Reset takes effect at the first edge with `rst`=1. A mid-stream reset discards both entries.

## Configuration
- `PIPE_STAGE_SKID_EN` defined: two-entry skid buffer as above; `count` reaches 2; `in_ready` is registered-only.
- Not defined: single register, no skid.
  - `in_ready` = `!freeze & !flush & !rst & (!out_valid_q | out_ready)`, which is combinational from `out_ready`.
  - `count` ∈ {0,1}; FULL state does not exist.
  - All other behaviour is identical.

## Test plan
- Reset then stream: `rst` 2 cycles, then send PC 0x0,0x4,0x8 with data 0xE3A0_1001..3 and `out_ready`=1. Required: `out_*` all 0 during reset; entries appear 1 cycle after accept, in order, one per cycle.
- Backpressure (skid): stream with `out_ready`=0 for 3 cycles. Required: `count` goes 1→2; `in_ready`=0 from the cycle after FULL; releasing `out_ready` drains both entries in order with no loss.
- Freeze: hold `freeze`=1 for 4 cycles mid-stream with `in_valid`=1. Required: `out_valid`=0, `in_ready`=0, stored PC/data unchanged; on release the held entry appears with the same values.
- Flush with `NOP_ON_FLUSH`=1 while FULL: required next cycle `out_valid`=1, `out_pc`=0, `out_data`=0xF000_0000, `count`=1, skid entry gone. Repeat with `NOP_ON_FLUSH`=0: `out_valid`=0, `count`=0.
- Flush and freeze asserted together: flush wins, giving the bubble as above. Simultaneous accept+drain in state ONE keeps `count`=1 and updates main to the new input.
- Macro undefined: repeat the backpressure scenario. Required: `count` ≤ 1, and `in_ready` follows `out_ready` in the same cycle when `out_valid`=1.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register carrying a PC and a payload, with freeze, flush and NOP bubble.
// Define PIPE_STAGE_SKID_EN to add a second (skid) entry and make in_ready registered-only.
module pipe_stage_reg #(
   parameter int unsigned PC_W         = 32,
   parameter int unsigned DATA_W       = 32,
   parameter logic [31:0] NOP_VALUE    = 32'hF000_0000,
   parameter bit          NOP_ON_FLUSH = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        count
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   localparam logic [DATA_W-1:0] NOP_DATA = DATA_W'(NOP_VALUE);

   state_e            state_q;
   logic [PC_W-1:0]   main_pc_q;
   logic [DATA_W-1:0] main_data_q;
   logic              main_valid;
   logic              accept;
   logic              drain;

   // Handshake: a transfer happens on a side only in a cycle where both valid and ready are 1;
   // freeze/flush/rst drop in_ready and mask out_valid so neither side can transfer.
   assign main_valid = (state_q != ST_EMPTY);
   assign out_valid  = main_valid & ~freeze & ~flush & ~rst;
   assign out_pc     = main_pc_q;
   assign out_data   = main_data_q;
   assign count      = state_q;
   assign accept     = in_valid & in_ready;
   assign drain      = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
   logic [PC_W-1:0]   skid_pc_q;
   logic [DATA_W-1:0] skid_data_q;

   // Only registered state gates in_ready, so out_ready never reaches it combinationally.
   assign in_ready = (state_q != ST_FULL) & ~freeze & ~flush & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         main_pc_q   <= '0;
         main_data_q <= '0;
         skid_pc_q   <= '0;
         skid_data_q <= '0;
      end else if (flush) begin
         state_q     <= NOP_ON_FLUSH ? ST_ONE : ST_EMPTY;
         main_pc_q   <= '0;
         main_data_q <= NOP_DATA;
         skid_pc_q   <= '0;
         skid_data_q <= '0;
      end else if (!freeze) begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_q     <= ST_ONE;
                  main_pc_q   <= in_pc;
                  main_data_q <= in_data;
               end
            end
            ST_ONE: begin
               if (accept && drain) begin
                  main_pc_q   <= in_pc;
                  main_data_q <= in_data;
               end else if (accept) begin
                  state_q     <= ST_FULL;
                  skid_pc_q   <= in_pc;
                  skid_data_q <= in_data;
               end else if (drain) begin
                  state_q <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (drain) begin
                  state_q     <= ST_ONE;
                  main_pc_q   <= skid_pc_q;
                  main_data_q <= skid_data_q;
               end
            end
            default: state_q <= ST_EMPTY;
         endcase
      end
   end
`else
   // Single entry: the slot frees up in the same cycle the downstream drains it.
   assign in_ready = ~freeze & ~flush & ~rst & (~main_valid | out_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         main_pc_q   <= '0;
         main_data_q <= '0;
      end else if (flush) begin
         state_q     <= NOP_ON_FLUSH ? ST_ONE : ST_EMPTY;
         main_pc_q   <= '0;
         main_data_q <= NOP_DATA;
      end else if (!freeze) begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_q     <= ST_ONE;
                  main_pc_q   <= in_pc;
                  main_data_q <= in_data;
               end
            end
            ST_ONE: begin
               if (accept) begin
                  main_pc_q   <= in_pc;
                  main_data_q <= in_data;
               end else if (drain) begin
                  state_q <= ST_EMPTY;
               end
            end
            default: state_q <= ST_EMPTY;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: two instances (bubble / no bubble on flush) share stimulus.
// Expectations adapt to PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        rst, freeze, flush, in_valid, out_ready;
   logic [31:0] in_pc, in_data;

   logic        in_ready, out_valid;
   logic [31:0] out_pc, out_data;
   logic [1:0]  count;
   logic        in_ready0, out_valid0;
   logic [31:0] out_pc0, out_data0;
   logic [1:0]  count0;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.NOP_ON_FLUSH(1'b1)) u_dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_data(out_data),
      .count(count)
   );

   pipe_stage_reg #(.NOP_ON_FLUSH(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready0), .in_pc(in_pc), .in_data(in_data),
      .out_valid(out_valid0), .out_ready(out_ready), .out_pc(out_pc0), .out_data(out_data0),
      .count(count0)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] data);
      in_valid = v;
      in_pc    = pc;
      in_data  = data;
      #1;
   endtask

   initial begin
      rst = 1'b1; freeze = 1'b0; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0);

      // reset
      tick(); tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_pc", out_pc, 0);
      check("rst_out_data", out_data, 0);
      check("rst_count", count, 0);
      check("rst_in_ready", in_ready, 0);

      // stream three entries, out_ready=1
      rst = 1'b0; out_ready = 1'b1;
      drive(1'b1, 32'h0, 32'hE3A0_1001);
      check("s0_in_ready", in_ready, 1);
      tick();
      check("s0_out_valid", out_valid, 1);
      check("s0_out_pc", out_pc, 32'h0);
      check("s0_out_data", out_data, 32'hE3A0_1001);
      check("s0_count", count, 1);
      drive(1'b1, 32'h4, 32'hE3A0_1002);
      check("s1_in_ready", in_ready, 1);
      tick();
      check("s1_out_pc", out_pc, 32'h4);
      check("s1_out_data", out_data, 32'hE3A0_1002);
      check("s1_count", count, 1);
      drive(1'b1, 32'h8, 32'hE3A0_1003);
      tick();
      check("s2_out_pc", out_pc, 32'h8);
      check("s2_out_data", out_data, 32'hE3A0_1003);
      drive(1'b0, 32'h0, 32'h0);
      tick();
      check("s3_out_valid", out_valid, 0);
      check("s3_count", count, 0);

      // backpressure
      out_ready = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      drive(1'b1, 32'h10, 32'hA1);
      check("bp_a_in_ready", in_ready, 1);
      tick();
      check("bp_a_count", count, 1);
      check("bp_a_out_pc", out_pc, 32'h10);
      drive(1'b1, 32'h14, 32'hA2);
      check("bp_b_in_ready", in_ready, 1);
      tick();
      check("bp_b_count", count, 2);
      drive(1'b1, 32'h18, 32'hA3);
      check("bp_full_in_ready", in_ready, 0);
      tick();
      check("bp_hold_count", count, 2);
      check("bp_hold_out_pc", out_pc, 32'h10);
      out_ready = 1'b1; #1;
      check("bp_rel_in_ready", in_ready, 0);
      check("bp_rel_out_valid", out_valid, 1);
      check("bp_rel_out_pc", out_pc, 32'h10);
      tick();
      check("bp_d1_out_pc", out_pc, 32'h14);
      check("bp_d1_out_data", out_data, 32'hA2);
      check("bp_d1_count", count, 1);
      check("bp_d1_in_ready", in_ready, 1);
      tick();
      check("bp_d2_out_pc", out_pc, 32'h18);
      check("bp_d2_out_data", out_data, 32'hA3);
      check("bp_d2_count", count, 1);
`else
      drive(1'b1, 32'h10, 32'hA1);
      check("bp_a_in_ready", in_ready, 1);
      tick();
      check("bp_a_count", count, 1);
      check("bp_a_out_pc", out_pc, 32'h10);
      drive(1'b1, 32'h14, 32'hA2);
      check("bp_b_in_ready", in_ready, 0);
      tick();
      check("bp_b_count", count, 1);
      check("bp_b_out_pc", out_pc, 32'h10);
      tick();
      check("bp_c_count", count, 1);
      out_ready = 1'b1; #1;
      check("bp_follow_hi", in_ready, 1);
      out_ready = 1'b0; #1;
      check("bp_follow_lo", in_ready, 0);
      out_ready = 1'b1; #1;
      tick();
      check("bp_d1_out_pc", out_pc, 32'h14);
      check("bp_d1_out_data", out_data, 32'hA2);
      check("bp_d1_count", count, 1);
`endif
      drive(1'b0, 32'h0, 32'h0);
      tick();
      check("bp_end_count", count, 0);

      // freeze mid-stream
      out_ready = 1'b1;
      drive(1'b1, 32'h20, 32'hD1);
      tick();
      check("fz_load_pc", out_pc, 32'h20);
      drive(1'b1, 32'h24, 32'hD2);
      freeze = 1'b1; #1;
      for (int i = 0; i < 4; i++) begin
         check("fz_out_valid", out_valid, 0);
         check("fz_in_ready", in_ready, 0);
         check("fz_out_pc", out_pc, 32'h20);
         check("fz_out_data", out_data, 32'hD1);
         check("fz_count", count, 1);
         tick();
      end
      freeze = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      check("fz_rel_out_valid", out_valid, 1);
      check("fz_rel_out_pc", out_pc, 32'h20);
      check("fz_rel_out_data", out_data, 32'hD1);
      tick();
      check("fz_end_count", count, 0);

      // flush with stage loaded
      out_ready = 1'b0;
      drive(1'b1, 32'h30, 32'hF1);
      tick();
`ifdef PIPE_STAGE_SKID_EN
      drive(1'b1, 32'h34, 32'hF2);
      tick();
      check("fl_full_count", count, 2);
`endif
      drive(1'b1, 32'h38, 32'hF3);
      flush = 1'b1; #1;
      check("fl_in_ready", in_ready, 0);
      check("fl_out_valid", out_valid, 0);
      tick();
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      check("fl_nop_valid", out_valid, 1);
      check("fl_nop_pc", out_pc, 0);
      check("fl_nop_data", out_data, 32'hF000_0000);
      check("fl_nop_count", count, 1);
      check("fl0_valid", out_valid0, 0);
      check("fl0_count", count0, 0);
      check("fl0_in_ready", in_ready0, 1);
      out_ready = 1'b1; #1;
      tick();
      check("fl_drained_count", count, 0);
      check("fl0_drained_count", count0, 0);

      // flush and freeze together
      out_ready = 1'b0;
      drive(1'b1, 32'h3C, 32'hF4);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      freeze = 1'b1; flush = 1'b1; #1;
      tick();
      freeze = 1'b0; flush = 1'b0; #1;
      check("ff_valid", out_valid, 1);
      check("ff_pc", out_pc, 0);
      check("ff_data", out_data, 32'hF000_0000);
      check("ff_count", count, 1);
      check("ff0_count", count0, 0);

      // mid-stream reset
      drive(1'b1, 32'h40, 32'hB1);
      tick();
      rst = 1'b1;
      drive(1'b0, 32'h0, 32'h0);
      tick();
      check("mr_count", count, 0);
      check("mr_out_valid", out_valid, 0);
      check("mr_out_pc", out_pc, 0);
      check("mr_out_data", out_data, 0);
      check("mr0_count", count0, 0);
      rst = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
